// File: rtl/hamming_arbitro.sv
`default_nettype none
// ============================================================================
// Module   : hamming_arbitro
// Purpose  : Round-robin arbiter that shares one Hamming(15,11) encoder
//            between N_REQ requesters. It feeds a registered output slot
//            with a valid/ready handshake, tags each codeword with its
//            source index, and counts the codewords accepted downstream.
// Option   : HAMMING_PARIDADE_GLOBAL_EN - when defined, saida[15] carries
//            the overall (SECDED) parity of saida[14:0]; otherwise it is 0.
// Revision : 1.0 - initial release
// ============================================================================
module hamming_arbitro #(
    parameter  int N_REQ = 4,
    localparam int ID_W  = $clog2(N_REQ)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [N_REQ-1:0]      req_valid,
    input  logic [N_REQ*11-1:0]   req_dado,
    output logic [N_REQ-1:0]      req_ready,
    output logic                  saida_valid,
    input  logic                  saida_ready,
    output logic [15:0]           saida,
    output logic [ID_W-1:0]       saida_id,
    output logic [15:0]           contador
);

    localparam logic [ID_W-1:0] c_ULTIMO = ID_W'(N_REQ - 1);

    logic [ID_W-1:0] r_prox;
    logic            r_valid;
    logic [15:0]     r_saida;
    logic [ID_W-1:0] r_id;
    logic [15:0]     r_cont;

    logic            w_livre;
    logic            w_achou;
    logic            w_concede;
    logic [ID_W-1:0] w_sel;
    logic [ID_W:0]   w_idx;
    logic [10:0]     w_dado;

    // Hamming(15,11) codeword: {p4,p3,p2,p1,d}, bit 15 optional overall parity
    function automatic logic [15:0] codificar(input logic [10:0] d);
        logic p1, p2, p3, p4;
        logic [15:0] cw;
        p1 = d[0] ^ d[1] ^ d[3] ^ d[4] ^ d[6] ^ d[8] ^ d[10];
        p2 = d[0] ^ d[2] ^ d[3] ^ d[5] ^ d[6] ^ d[9] ^ d[10];
        p3 = d[1] ^ d[2] ^ d[3] ^ d[7] ^ d[8] ^ d[9] ^ d[10];
        p4 = d[4] ^ d[5] ^ d[6] ^ d[7] ^ d[8] ^ d[9] ^ d[10];
        cw = {1'b0, p4, p3, p2, p1, d};
`ifdef HAMMING_PARIDADE_GLOBAL_EN
        cw[15] = ^cw[14:0];
`else
        cw[15] = 1'b0;
`endif
        return cw;
    endfunction

    // Slot can take a new codeword when empty or being drained this cycle
    assign w_livre = !r_valid || saida_ready;

    // Cyclic search for the first valid requester starting at the pointer;
    // the extra index bit absorbs prox+k before folding back below N_REQ
    always_comb begin
        w_achou = 1'b0;
        w_sel   = '0;
        w_idx   = '0;
        for (int k = 0; k < N_REQ; k++) begin
            w_idx = {1'b0, r_prox} + (ID_W+1)'(k);
            if (w_idx >= (ID_W+1)'(N_REQ)) begin
                w_idx = w_idx - (ID_W+1)'(N_REQ);
            end
            if (!w_achou && req_valid[w_idx[ID_W-1:0]]) begin
                w_achou = 1'b1;
                w_sel   = w_idx[ID_W-1:0];
            end
        end
    end

    // Grant is suppressed while reset is held so no requester sees a transfer
    assign w_concede = w_livre && w_achou && rst_n;
    assign req_ready = w_concede ? ({{(N_REQ-1){1'b0}}, 1'b1} << w_sel) : '0;
    assign w_dado    = req_dado[int'(w_sel)*11 +: 11];

    // Output slot, round-robin pointer and accepted-codeword counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prox  <= '0;
            r_valid <= 1'b0;
            r_saida <= '0;
            r_id    <= '0;
            r_cont  <= '0;
        end else begin
            if (r_valid && saida_ready) begin
                r_cont <= r_cont + 16'd1;
            end
            if (w_concede) begin
                r_saida <= codificar(w_dado);
                r_id    <= w_sel;
                r_valid <= 1'b1;
                r_prox  <= (w_sel == c_ULTIMO) ? '0 : w_sel + ID_W'(1);
            end else if (saida_ready) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign saida_valid = r_valid;
    assign saida       = r_saida;
    assign saida_id    = r_id;
    assign contador    = r_cont;

endmodule
`default_nettype wire

// File: tb/tb_hamming_arbitro.sv
`default_nettype none
// ============================================================================
// Module   : tb_hamming_arbitro
// Purpose  : Self-checking bench for hamming_arbitro (N_REQ = 4). A negedge
//            reference model predicts grants and pushes expected codewords
//            into a queue; accepted codewords are popped and compared.
// Revision : 1.0 - initial release
// ============================================================================
module tb_hamming_arbitro;

    localparam int N = 4;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [N-1:0]    req_valid = '0;
    logic [N*11-1:0] req_dado = '0;
    logic [N-1:0]    req_ready;
    logic            saida_valid;
    logic            saida_ready = 1'b0;
    logic [15:0]     saida;
    logic [1:0]      saida_id;
    logic [15:0]     contador;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct packed {
        logic [1:0]  id;
        logic [15:0] cw;
    } exp_t;
    exp_t fila[$];

    // reference model state (monitor only)
    logic        m_valid = 1'b0;
    int          m_prox  = 0;
    logic [15:0] m_cont  = '0;
    int          m_g;
    int          m_idx;
    logic [N-1:0] m_rr;
    exp_t        m_e;

    hamming_arbitro #(.N_REQ(N)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_dado   (req_dado),
        .req_ready  (req_ready),
        .saida_valid(saida_valid),
        .saida_ready(saida_ready),
        .saida      (saida),
        .saida_id   (saida_id),
        .contador   (contador)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] modelo_cw(input logic [10:0] d);
        logic [15:0] c;
        c[10:0] = d;
        c[11] = d[0] ^ d[1] ^ d[3] ^ d[4] ^ d[6] ^ d[8] ^ d[10];
        c[12] = d[0] ^ d[2] ^ d[3] ^ d[5] ^ d[6] ^ d[9] ^ d[10];
        c[13] = d[1] ^ d[2] ^ d[3] ^ d[7] ^ d[8] ^ d[9] ^ d[10];
        c[14] = d[4] ^ d[5] ^ d[6] ^ d[7] ^ d[8] ^ d[9] ^ d[10];
`ifdef HAMMING_PARIDADE_GLOBAL_EN
        c[15] = ^c[14:0];
`else
        c[15] = 1'b0;
`endif
        return c;
    endfunction

    // Scoreboard monitor: sampled mid-cycle, between driving and the next edge
    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                m_valid = 1'b0;
                m_prox  = 0;
                m_cont  = '0;
                fila.delete();
            end else begin
                m_g = -1;
                if (!m_valid || saida_ready) begin
                    for (int k = 0; k < N; k++) begin
                        m_idx = (m_prox + k) % N;
                        if (m_g < 0 && req_valid[m_idx]) m_g = m_idx;
                    end
                end
                m_rr = (m_g >= 0) ? (N'(1) << m_g) : '0;
                n_cmp++;
                if (req_ready !== m_rr) begin
                    n_err++;
                    $display("FAIL grant: req_ready=%b expected %b at %0t", req_ready, m_rr, $time);
                end
                n_cmp++;
                if (saida_valid !== m_valid) begin
                    n_err++;
                    $display("FAIL valid: saida_valid=%b expected %b at %0t", saida_valid, m_valid, $time);
                end
                n_cmp++;
                if (contador !== m_cont) begin
                    n_err++;
                    $display("FAIL contador: got %h expected %h at %0t", contador, m_cont, $time);
                end
                if (m_valid && saida_ready) begin
                    n_cmp++;
                    if (fila.size() == 0) begin
                        n_err++;
                        $display("FAIL scoreboard: accept with empty queue at %0t", $time);
                    end else begin
                        m_e = fila.pop_front();
                        if (saida_id !== m_e.id || saida !== m_e.cw) begin
                            n_err++;
                            $display("FAIL codeword: id=%0d cw=%h expected id=%0d cw=%h at %0t",
                                     saida_id, saida, m_e.id, m_e.cw, $time);
                        end
                    end
                    m_cont = m_cont + 16'd1;
                end
                if (m_g >= 0) begin
                    m_e.id = 2'(m_g);
                    m_e.cw = modelo_cw(req_dado[m_g*11 +: 11]);
                    fila.push_back(m_e);
                    m_valid = 1'b1;
                    m_prox  = (m_g + 1) % N;
                end else if (saida_ready) begin
                    m_valid = 1'b0;
                end
            end
        end
    end

    task automatic set_dado(input int i, input logic [10:0] d);
        req_dado[i*11 +: 11] = d;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        req_valid = '1;
        saida_ready = 1'b1;
        @(posedge clk); #1;
        n_cmp++;
        if (saida_valid !== 1'b0 || saida !== 16'h0 || saida_id !== 2'd0 ||
            contador !== 16'h0 || req_ready !== '0) begin
            n_err++;
            $display("FAIL reset: v=%b s=%h id=%0d c=%h rr=%b expected all 0",
                     saida_valid, saida, saida_id, contador, req_ready);
        end
        req_valid = '0;
        rst_n = 1'b1;
    endtask

    task automatic test_single();
        logic [15:0] exp_cw;
`ifdef HAMMING_PARIDADE_GLOBAL_EN
        exp_cw = 16'h9801;
`else
        exp_cw = 16'h1801;
`endif
        set_dado(2, 11'h001);
        req_valid = 4'b0100;
        saida_ready = 1'b1;
        @(posedge clk); #1;
        req_valid = '0;
        n_cmp++;
        if (saida_valid !== 1'b1 || saida !== exp_cw || saida_id !== 2'd2) begin
            n_err++;
            $display("FAIL single: v=%b s=%h id=%0d expected 1 %h 2", saida_valid, saida, saida_id, exp_cw);
        end
        @(posedge clk); #1;
        n_cmp++;
        if (contador !== 16'd1 || saida_valid !== 1'b0) begin
            n_err++;
            $display("FAIL single_count: c=%h v=%b expected 1 0", contador, saida_valid);
        end
    endtask

    task automatic test_all();
        logic [15:0] exp_cw [4];
`ifdef HAMMING_PARIDADE_GLOBAL_EN
        exp_cw = '{16'hFFFF, 16'hC810, 16'h0000, 16'hFFFF};
`else
        exp_cw = '{16'h7FFF, 16'h4810, 16'h0000, 16'h7FFF};
`endif
        do_reset();
        set_dado(0, 11'h7FF);
        set_dado(1, 11'h010);
        set_dado(2, 11'h000);
        set_dado(3, 11'h7FF);
        req_valid = '1;
        saida_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            if (k == 3) req_valid = '0;
            n_cmp++;
            if (saida_id !== 2'(k) || saida !== exp_cw[k] || saida_valid !== 1'b1) begin
                n_err++;
                $display("FAIL all_%0d: id=%0d s=%h expected id=%0d s=%h", k, saida_id, saida, k, exp_cw[k]);
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_stall();
        logic [15:0] cw0;
        logic [15:0] c0;
        saida_ready = 1'b0;
        req_valid = '1;
        @(posedge clk); #1;
        cw0 = saida;
        c0 = contador;
        n_cmp++;
        if (saida_id !== 2'd0 || saida_valid !== 1'b1) begin
            n_err++;
            $display("FAIL stall_load: id=%0d v=%b expected 0 1", saida_id, saida_valid);
        end
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            n_cmp++;
            if (saida !== cw0 || saida_id !== 2'd0 || saida_valid !== 1'b1 ||
                req_ready !== '0 || contador !== c0) begin
                n_err++;
                $display("FAIL stall_%0d: s=%h id=%0d v=%b rr=%b c=%h expected %h 0 1 0 %h",
                         k, saida, saida_id, saida_valid, req_ready, contador, cw0, c0);
            end
        end
        saida_ready = 1'b1;
        @(posedge clk); #1;
        req_valid = '0;
        n_cmp++;
        if (saida_id !== 2'd1 || saida_valid !== 1'b1 || contador !== c0 + 16'd1) begin
            n_err++;
            $display("FAIL stall_release: id=%0d v=%b c=%h expected 1 1 %h", saida_id, saida_valid, contador, c0 + 16'd1);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_ptr_wrap();
        req_valid = 4'b1000;
        @(posedge clk); #1;
        req_valid = 4'b1001;
        n_cmp++;
        if (saida_id !== 2'd3) begin
            n_err++;
            $display("FAIL wrap_3: id=%0d expected 3", saida_id);
        end
        @(posedge clk); #1;
        req_valid = '0;
        n_cmp++;
        if (saida_id !== 2'd0 || saida_valid !== 1'b1) begin
            n_err++;
            $display("FAIL wrap_0: id=%0d v=%b expected 0 1", saida_id, saida_valid);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_async_reset();
        set_dado(1, 11'h555);
        req_valid = 4'b0010;
        saida_ready = 1'b0;
        @(posedge clk); #1;
        req_valid = '0;
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (saida_valid !== 1'b0 || saida !== 16'h0 || saida_id !== 2'd0 ||
            contador !== 16'h0 || req_ready !== '0) begin
            n_err++;
            $display("FAIL async_reset: v=%b s=%h id=%0d c=%h rr=%b expected all 0",
                     saida_valid, saida, saida_id, contador, req_ready);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        saida_ready = 1'b1;
        @(posedge clk); #1;
        n_cmp++;
        if (contador !== 16'h0 || saida_valid !== 1'b0) begin
            n_err++;
            $display("FAIL async_discard: c=%h v=%b expected 0 0", contador, saida_valid);
        end
    endtask

    task automatic test_contador_wrap();
        do_reset();
        req_valid = '1;
        saida_ready = 1'b1;
        repeat (65536) @(posedge clk);
        #1;
        n_cmp++;
        if (contador !== 16'hFFFF) begin
            n_err++;
            $display("FAIL count_max: c=%h expected ffff", contador);
        end
        @(posedge clk); #1;
        req_valid = '0;
        n_cmp++;
        if (contador !== 16'h0000) begin
            n_err++;
            $display("FAIL count_wrap: c=%h expected 0000", contador);
        end
        @(posedge clk); #1;
    endtask

    initial begin
        test_reset();
        test_single();
        test_all();
        test_stall();
        test_ptr_wrap();
        test_async_reset();
        test_contador_wrap();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
